// File: rtl/input_module_pkg.sv
// noc_pkg: shared FSM state encoding and LFSR feedback mask for the AXI-Stream packet generator.
package noc_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, FIN = 2'd2} state_e;
    // Right-shift Galois mask for x^32+x^22+x^2+x+1
    localparam logic [31:0] LFSR_POLY = 32'h8020_0003;
endpackage

// File: rtl/input_pattern_gen.sv
// input_pattern_gen: TDATA pattern register, incrementing by default or a 32-bit Galois LFSR
// when INPUT_MODULE_LFSR_EN is defined.
module input_pattern_gen
    import noc_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] seed,
    input  logic         step,
    output logic [W-1:0] value
);
    logic [W-1:0] r_value;
    logic [W-1:0] w_seed;
    logic [W-1:0] w_next;
`ifdef INPUT_MODULE_LFSR_EN
    if (W != 32) begin : g_width_chk
        $error("input_pattern_gen: LFSR pattern requires TDATAW == 32");
    end
    // An all-zero LFSR would lock up, so a zero seed falls back to 1
    assign w_seed = (seed == '0) ? W'(1) : seed;
    assign w_next = r_value[0] ? ((r_value >> 1) ^ W'(LFSR_POLY)) : (r_value >> 1);
`else
    assign w_seed = seed;
    assign w_next = r_value + 1'b1;
`endif
    always_ff @(posedge clk) begin
        if (rst) r_value <= '0;
        else if (load) r_value <= w_seed;
        else if (step) r_value <= w_next;
    end
    assign value = r_value;
endmodule

// File: rtl/input_module.sv
// input_module: AXI-Stream packet generator (round-robin TDEST, TID from packet count).
// Define INPUT_MODULE_LFSR_EN for LFSR TDATA instead of the incrementing pattern.
module input_module
    import noc_pkg::*;
#(
    parameter int          TDATAW   = 32,
    parameter int          TDESTW   = 4,
    parameter int          TIDW     = 2,
    parameter int          PKT_LEN  = 4,
    parameter int          NUM_PKTS = 8,
    parameter int          NUM_DEST = 4,
    parameter logic [31:0] SEED     = 32'h0000_0001
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              START,
    output logic              BUSY,
    output logic              DONE,
    output logic              AXIS_M_TVALID,
    input  logic              AXIS_M_TREADY,
    output logic [TDATAW-1:0] AXIS_M_TDATA,
    output logic              AXIS_M_TLAST,
    output logic [TIDW-1:0]   AXIS_M_TID,
    output logic [TDESTW-1:0] AXIS_M_TDEST,
    input  logic              AXIS_S_TVALID,
    output logic              AXIS_S_TREADY,
    input  logic [TDATAW-1:0] AXIS_S_TDATA,
    input  logic              AXIS_S_TLAST,
    input  logic [TIDW-1:0]   AXIS_S_TID,
    input  logic [TDESTW-1:0] AXIS_S_TDEST
);
    localparam int BW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    localparam logic [TDATAW-1:0] SEED_W = TDATAW'(SEED);
    state_e             r_state;
    logic [BW-1:0]      r_beat_cnt;
    logic [15:0]        r_pkt_cnt;
    logic [TDESTW-1:0]  r_dest_cnt;
    logic [TDATAW-1:0]  w_value;
    logic               w_valid;
    logic               w_hs;
    logic               w_last;
    logic               w_load;
    logic               w_unused;
    assign w_valid = (r_state == SEND);
    assign w_hs    = w_valid & AXIS_M_TREADY;
    assign w_last  = (r_beat_cnt == BW'(PKT_LEN - 1));
    assign w_load  = (r_state == IDLE) & START;
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= IDLE;
            r_beat_cnt <= '0;
            r_pkt_cnt  <= '0;
            r_dest_cnt <= '0;
        end else if (r_state == IDLE) begin
            if (START) begin
                r_state    <= SEND;
                r_beat_cnt <= '0;
                r_pkt_cnt  <= '0;
                r_dest_cnt <= '0;
            end
        end else if (r_state != SEND) begin
            r_state <= IDLE;
        end else if (w_hs) begin
            if (w_last) begin
                r_beat_cnt <= '0;
                r_pkt_cnt  <= r_pkt_cnt + 1'b1;
                r_dest_cnt <= (r_dest_cnt == TDESTW'(NUM_DEST - 1)) ? '0 : r_dest_cnt + 1'b1;
                if (r_pkt_cnt == 16'(NUM_PKTS - 1)) r_state <= FIN;
            end else begin
                r_beat_cnt <= r_beat_cnt + 1'b1;
            end
        end
    end
    input_pattern_gen #(.W(TDATAW)) u_pat (
        .clk   (CLK),
        .rst   (RST),
        .load  (w_load),
        .seed  (SEED_W),
        .step  (w_hs),
        .value (w_value)
    );
    // Payload fields read as zero whenever no beat is being offered
    assign AXIS_M_TVALID = w_valid;
    assign AXIS_M_TDATA  = w_valid ? w_value : '0;
    assign AXIS_M_TLAST  = w_valid & w_last;
    assign AXIS_M_TID    = w_valid ? r_pkt_cnt[TIDW-1:0] : '0;
    assign AXIS_M_TDEST  = w_valid ? r_dest_cnt : '0;
    assign BUSY          = (r_state == SEND) | (r_state == FIN);
    assign DONE          = (r_state == FIN);
    assign AXIS_S_TREADY = 1'b0;
    assign w_unused = ^{AXIS_S_TVALID, AXIS_S_TDATA, AXIS_S_TLAST, AXIS_S_TID, AXIS_S_TDEST};
endmodule
